// File: rtl/uart_tx_arbiter.sv
// N-port byte arbiter feeding one UART transmitter: per-port holding registers,
// round-robin selection and an optional line lock held until a port sends 0x0A.
module uart_tx_arbiter #(
  parameter int N            = 4,
  parameter int LINE_LOCK    = 1,
  parameter int LOCK_TIMEOUT = 1_000_000
) (
  input  logic           SYSCLK,
  input  logic           RESET,
  input  logic [8*N-1:0] reqData,
  input  logic [N-1:0]   reqValid,
  output logic [N-1:0]   reqReady,
  output logic [7:0]     txData,
  output logic           txStb,
  input  logic           txRdy,
  output logic [N-1:0]   grant,
  output logic           locked
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, STROBE, SETTLE, WAITRDY} state_t;

  state_t        stateReg;
  logic [N-1:0]  fullVec;
  logic [7:0]    holdByte [N];
  logic [N-1:0]  winClear;
  logic [N-1:0]  eligible;
  logic [N-1:0]  winOneHot;
  logic [IW-1:0] winIdx;
  logic          found;
  logic          startXfer;
  logic [IW-1:0] lastReg;
  logic [IW-1:0] lockPortReg;
  logic          lockedReg;
  logic [CW-1:0] idleCountReg;

  // One holding register per port; it never captures and loses a win in the same cycle.
  for (genvar gi = 0; gi < N; gi++) begin : gHold
    logic       fullReg;
    logic [7:0] byteReg;

    always_ff @(posedge SYSCLK) begin
      if (RESET) begin
        fullReg <= 1'b0;
        byteReg <= 8'h00;
      end else if (reqValid[gi] && !fullReg) begin
        fullReg <= 1'b1;
        byteReg <= reqData[8*gi +: 8];
      end else if (winClear[gi]) begin
        fullReg <= 1'b0;
      end
    end

    assign fullVec[gi]  = fullReg;
    assign holdByte[gi] = byteReg;
  end

  assign reqReady = ~fullVec;
  assign locked   = lockedReg;

  // Round-robin search starting one past the last winner.
  always_comb begin
    eligible = fullVec;
    if (LINE_LOCK != 0 && lockedReg)
      eligible = fullVec & (N'(1) << lockPortReg);
    found  = 1'b0;
    winIdx = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && eligible[(int'(lastReg) + k) % N]) begin
        found  = 1'b1;
        winIdx = IW'((int'(lastReg) + k) % N);
      end
    end
  end

  assign winOneHot = N'(1) << winIdx;
  assign startXfer = (stateReg == IDLE) && txRdy && found;
  assign winClear  = startXfer ? winOneHot : '0;

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      stateReg     <= IDLE;
      txStb        <= 1'b0;
      txData       <= 8'h00;
      grant        <= '0;
      lastReg      <= IW'(N - 1);
      lockedReg    <= 1'b0;
      lockPortReg  <= '0;
      idleCountReg <= '0;
    end else begin
      txStb <= 1'b0;
      if (lockedReg && fullVec[lockPortReg])
        idleCountReg <= '0;
      case (stateReg)
        IDLE: begin
          if (startXfer) begin
            stateReg     <= STROBE;
            txStb        <= 1'b1;
            txData       <= holdByte[winIdx];
            grant        <= winOneHot;
            lastReg      <= winIdx;
            idleCountReg <= '0;
            if (LINE_LOCK != 0) begin
              lockedReg   <= (holdByte[winIdx] != 8'h0A);
              lockPortReg <= winIdx;
            end
          end else if (lockedReg && !fullVec[lockPortReg]) begin
            // Idle lock timer: release once the owner has been silent long enough.
            if (idleCountReg == CW'(LOCK_TIMEOUT - 1)) begin
              lockedReg    <= 1'b0;
              idleCountReg <= '0;
            end else begin
              idleCountReg <= idleCountReg + CW'(1);
            end
          end
        end
        STROBE:  stateReg <= SETTLE;
        SETTLE:  stateReg <= WAITRDY;
        WAITRDY: if (txRdy) stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule
